id_scoreboard: RTL and testbench

ID_SCOREBOARD -- requirements
Module: id_scoreboard

---
 rtl/id_scoreboard.sv | 136 +++++++++++++
 tb/tb_id_scoreboard.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: ID-stage scoreboard tracking multi-cycle writebacks, resolving operands and handing off to EX.
// Define ID_SCB_FWD_EN to build the forwarding muxes; without it any forward-source match stalls instead.
module id_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_FWD        = 3,
    parameter int MAX_OUT        = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]          id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0]          id_rs2_i,
    input  logic                               id_use1_i,
    input  logic                               id_use2_i,
    input  logic [REG_ADDR_WIDTH-1:0]          id_rd_i,
    input  logic                               id_rd_wr_i,
    input  logic                               id_long_i,
    input  logic [DATA_WIDTH-1:0]              rf_rs1_i,
    input  logic [DATA_WIDTH-1:0]              rf_rs2_i,
    input  logic [NUM_FWD-1:0]                 fwd_wr_i,
    input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0]  fwd_waddr_i,
    input  logic [NUM_FWD*DATA_WIDTH-1:0]      fwd_data_i,
    input  logic [NUM_FWD-1:0]                 fwd_ld_i,
    input  logic                               lo_done_i,
    input  logic [REG_ADDR_WIDTH-1:0]          lo_waddr_i,
    input  logic                               e_ready_i,
    input  logic                               flush_i,
    output logic                               stall_o,
    output logic                               e_valid_o,
    output logic [DATA_WIDTH-1:0]              e_rs1_o,
    output logic [DATA_WIDTH-1:0]              e_rs2_o,
    output logic [REG_ADDR_WIDTH-1:0]          e_rd_o,
    output logic                               e_rd_wr_o,
    output logic                               e_long_o,
    output logic [3:0]                         outstanding_o
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    logic [NREG-1:0]           pend_q, pend_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      e_valid_q, e_valid_d;
    logic [DATA_WIDTH-1:0]     e_rs1_q, e_rs2_q;
    logic [REG_ADDR_WIDTH-1:0] e_rd_q;
    logic                      e_rd_wr_q, e_long_q;
    logic                      blk1, blk2, hazard, issue, inc, dec;
    logic [DATA_WIDTH-1:0]     op1, op2;

`ifdef ID_SCB_FWD_EN
    // Walk oldest to youngest so the youngest match wins; bit DATA_WIDTH flags a load still in flight.
    function automatic logic [DATA_WIDTH:0] fwd_pick(input logic [REG_ADDR_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] rf);
        logic [DATA_WIDTH:0] r;
        r = {1'b0, rf};
        for (int j = NUM_FWD - 1; j >= 0; j--)
            if (fwd_wr_i[j] && fwd_waddr_i[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == a)
                r = {fwd_ld_i[j], fwd_data_i[j*DATA_WIDTH +: DATA_WIDTH]};
        return a == '0 ? '0 : r;
    endfunction
`else
    function automatic logic fwd_hit(input logic [REG_ADDR_WIDTH-1:0] a);
        logic h;
        h = 1'b0;
        for (int j = 0; j < NUM_FWD; j++)
            h = h | (fwd_wr_i[j] && fwd_waddr_i[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == a);
        return h && a != '0;
    endfunction

    logic unused_fwd;
    assign unused_fwd = ^{fwd_data_i, fwd_ld_i};
`endif

    always_comb begin
`ifdef ID_SCB_FWD_EN
        {blk1, op1} = fwd_pick(id_rs1_i, rf_rs1_i);
        {blk2, op2} = fwd_pick(id_rs2_i, rf_rs2_i);
`else
        blk1 = fwd_hit(id_rs1_i);
        blk2 = fwd_hit(id_rs2_i);
        op1  = id_rs1_i == '0 ? '0 : rf_rs1_i;
        op2  = id_rs2_i == '0 ? '0 : rf_rs2_i;
`endif
        // Pending bit 0 is never set, so register 0 can never raise a scoreboard hazard.
        hazard = (id_use1_i && (blk1 || pend_q[id_rs1_i]))
               || (id_use2_i && (blk2 || pend_q[id_rs2_i]))
               || (id_rd_wr_i && pend_q[id_rd_i])
               || (id_long_i && cnt_q == MAX_CNT);
    end

    assign stall_o   = id_valid_i & (hazard | (e_valid_q & ~e_ready_i));
    assign issue     = id_valid_i & ~stall_o & ~flush_i;
    assign inc       = issue & id_long_i;
    assign dec       = lo_done_i & (cnt_q != 4'd0);
    assign cnt_d     = (inc & ~dec) ? cnt_q + 4'd1 : (dec & ~inc) ? cnt_q - 4'd1 : cnt_q;
    assign e_valid_d = issue | (e_valid_q & ~e_ready_i & ~flush_i);

    // Set after clear so a same-cycle issue to the retiring register stays pending.
    always_comb begin
        pend_d = pend_q;
        if (lo_done_i) pend_d[lo_waddr_i] = 1'b0;
        if (inc && id_rd_i != '0) pend_d[id_rd_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            cnt_q     <= '0;
            e_valid_q <= 1'b0;
            e_rs1_q   <= '0;
            e_rs2_q   <= '0;
            e_rd_q    <= '0;
            e_rd_wr_q <= 1'b0;
            e_long_q  <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            e_valid_q <= e_valid_d;
            if (issue) begin
                e_rs1_q   <= op1;
                e_rs2_q   <= op2;
                e_rd_q    <= id_rd_i;
                e_rd_wr_q <= id_rd_wr_i;
                e_long_q  <= id_long_i;
            end
        end
    end

    assign e_valid_o     = e_valid_q;
    assign e_rs1_o       = e_rs1_q;
    assign e_rs2_o       = e_rs2_q;
    assign e_rd_o        = e_rd_q;
    assign e_rd_wr_o     = e_rd_wr_q;
    assign e_long_o      = e_long_q;
    assign outstanding_o = cnt_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scenarios plus randomized traffic checked against a register-level reference model.
module tb_id_scoreboard;
`ifdef ID_SCB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use1, id_use2, id_rd_wr, id_long;
    logic [4:0]  id_rs1, id_rs2, id_rd, lo_waddr;
    logic [31:0] rf_rs1, rf_rs2;
    logic [2:0]  fwd_wr, fwd_ld;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_data;
    logic        lo_done, e_ready, flush;
    logic        stall_o, e_valid_o, e_rd_wr_o, e_long_o;
    logic [31:0] e_rs1_o, e_rs2_o;
    logic [4:0]  e_rd_o;
    logic [3:0]  outstanding_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          pend[32];
    int          cnt;
    logic        ev, erdwr, elong;
    logic [31:0] ers1, ers2;
    logic [4:0]  erd;
    logic        exp_stall, exp_issue;
    logic [31:0] exp_op1, exp_op2;

    id_scoreboard #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_FWD(3), .MAX_OUT(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use1_i(id_use1), .id_use2_i(id_use2), .id_rd_i(id_rd),
        .id_rd_wr_i(id_rd_wr), .id_long_i(id_long),
        .rf_rs1_i(rf_rs1), .rf_rs2_i(rf_rs2),
        .fwd_wr_i(fwd_wr), .fwd_waddr_i(fwd_waddr), .fwd_data_i(fwd_data), .fwd_ld_i(fwd_ld),
        .lo_done_i(lo_done), .lo_waddr_i(lo_waddr),
        .e_ready_i(e_ready), .flush_i(flush),
        .stall_o(stall_o), .e_valid_o(e_valid_o), .e_rs1_o(e_rs1_o), .e_rs2_o(e_rs2_o),
        .e_rd_o(e_rd_o), .e_rd_wr_o(e_rd_wr_o), .e_long_o(e_long_o), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, required completion");
        $fatal(1);
    end

    // Youngest matching source first; returns {blocks, operand}.
    function automatic logic [32:0] m_src(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 33'd0;
        for (int j = 0; j < 3; j++)
            if (fwd_wr[j] && fwd_waddr[j*5 +: 5] == a)
                return FWD ? {fwd_ld[j], fwd_data[j*32 +: 32]} : {1'b1, rf};
        return {1'b0, rf};
    endfunction

    task automatic m_eval;
        logic [32:0] s1, s2;
        bit haz;
        s1 = m_src(id_rs1, rf_rs1);
        s2 = m_src(id_rs2, rf_rs2);
        haz = (id_use1 && (s1[32] || (id_rs1 != 0 && pend[id_rs1])))
           || (id_use2 && (s2[32] || (id_rs2 != 0 && pend[id_rs2])))
           || (id_rd_wr && id_rd != 0 && pend[id_rd])
           || (id_long && cnt == MAXO);
        exp_stall = id_valid && (haz || (ev && !e_ready));
        exp_issue = id_valid && !exp_stall && !flush;
        exp_op1 = s1[31:0];
        exp_op2 = s2[31:0];
    endtask

    task automatic m_reset;
        foreach (pend[r]) pend[r] = 0;
        cnt = 0; ev = 0; ers1 = 0; ers2 = 0; erd = 0; erdwr = 0; elong = 0;
    endtask

    task automatic m_commit;
        int inc, dec;
        inc = (exp_issue && id_long) ? 1 : 0;
        dec = (lo_done && cnt > 0) ? 1 : 0;
        if (lo_done) pend[lo_waddr] = 0;
        if (inc == 1 && id_rd != 0) pend[id_rd] = 1;
        cnt = cnt + inc - dec;
        if (exp_issue) begin
            ev = 1; ers1 = exp_op1; ers2 = exp_op2; erd = id_rd; erdwr = id_rd_wr; elong = id_long;
        end else if (e_ready || flush) ev = 0;
    endtask

    task automatic settle;
        #1;
        m_eval;
    endtask

    task automatic tick;
        m_eval;
        @(posedge clk);
        m_commit;
        #1;
    endtask

    task automatic idle;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        id_rd = 0; id_rd_wr = 0; id_long = 0; rf_rs1 = 0; rf_rs2 = 0;
        fwd_wr = 0; fwd_waddr = 0; fwd_data = 0; fwd_ld = 0;
        lo_done = 0; lo_waddr = 0; e_ready = 1; flush = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic lg);
        id_valid = 1; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
        id_rd = rd; id_rd_wr = wr; id_long = lg;
    endtask

    task automatic drain;
        idle;
        for (int r = 0; r < 32; r++) begin
            lo_done = 1; lo_waddr = 5'(r);
            tick;
        end
        idle;
        tick;
    endtask

    task automatic test_reset;
        idle;
        rst_n = 0;
        m_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({e_valid_o, e_rd_wr_o, e_long_o} !== 3'b000 || e_rs1_o !== 0 || e_rs2_o !== 0 || e_rd_o !== 0 || outstanding_o !== 0) begin
            errors++;
            $display("FAIL reset_state: valid=%b rs1=%h rs2=%h rd=%0d wr=%b long=%b out=%0d, required all zero",
                     e_valid_o, e_rs1_o, e_rs2_o, e_rd_o, e_rd_wr_o, e_long_o, outstanding_o);
        end
        rst_n = 1;
        set_id(5'd1, 1, 5'd2, 1, 5'd6, 1, 1);
        rf_rs1 = 32'hCAFE0001; rf_rs2 = 32'hCAFE0002;
        tick;
        idle;
        checks++;
        if (outstanding_o !== 4'd1 || e_valid_o !== 1'b1 || e_rs1_o !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL pre_reset_issue: out=%0d valid=%b rs1=%h, required 1 1 cafe0001", outstanding_o, e_valid_o, e_rs1_o);
        end
        #3 rst_n = 0;
        #1;
        m_reset;
        checks++;
        if (e_valid_o !== 1'b0 || outstanding_o !== 4'd0 || e_rs1_o !== 0 || e_rd_o !== 0 || e_long_o !== 0) begin
            errors++;
            $display("FAIL async_reset: valid=%b out=%0d rs1=%h rd=%0d long=%b, required zero", e_valid_o, outstanding_o, e_rs1_o, e_rd_o, e_long_o);
        end
        @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        lo_done = 1; lo_waddr = 5'd6;
        tick;
        lo_done = 0;
        checks++;
        if (outstanding_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_late_done: outstanding=%0d, required 0", outstanding_o);
        end
        set_id(5'd6, 1, 5'd0, 0, 5'd7, 1, 0);
        settle;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending_cleared: stall=%b, required 0", stall_o);
        end
        tick;
        idle;
        tick;
    endtask

    task automatic test_forward;
        drain;
        set_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        rf_rs1 = 32'h0BAD; rf_rs2 = 32'h0B0B;
        tick;
        set_id(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
        rf_rs1 = 32'hDEAD;
        fwd_wr = 3'b001; fwd_waddr = 15'd5; fwd_data = 96'h1234;
        settle;
        checks++;
        if (stall_o !== !FWD) begin
            errors++;
            $display("FAIL fwd_stall: stall=%b, required %b", stall_o, !FWD);
        end
        tick;
        checks++;
        if (e_valid_o !== FWD || e_rs1_o !== (FWD ? 32'h1234 : 32'h0BAD)) begin
            errors++;
            $display("FAIL fwd_operand: valid=%b rs1=%h, required %b %h", e_valid_o, e_rs1_o, FWD, FWD ? 32'h1234 : 32'h0BAD);
        end
    endtask

    task automatic test_load_use;
        idle;
        tick;
        set_id(5'd0, 0, 5'd7, 1, 5'd1, 1, 0);
        rf_rs2 = 32'h5151;
        fwd_wr = 3'b001; fwd_waddr = 15'd7; fwd_ld = 3'b001; fwd_data = 96'h77;
        settle;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b, required 1", stall_o);
        end
        tick;
        fwd_wr = 3'b010; fwd_ld = 3'b000; fwd_waddr = {5'd0, 5'd7, 5'd0}; fwd_data = {32'd0, 32'hAA, 32'd0};
        settle;
        checks++;
        if (stall_o !== !FWD) begin
            errors++;
            $display("FAIL load_use_resolve: stall=%b, required %b", stall_o, !FWD);
        end
        tick;
        checks++;
        if (e_valid_o !== FWD || e_rs2_o !== (FWD ? 32'hAA : ers2)) begin
            errors++;
            $display("FAIL load_use_operand: valid=%b rs2=%h, required %b %h", e_valid_o, e_rs2_o, FWD, FWD ? 32'hAA : ers2);
        end
        idle;
        tick;
    endtask

    task automatic test_long_dep;
        drain;
        set_id(5'd1, 1, 5'd2, 1, 5'd3, 1, 1);
        tick;
        checks++;
        if (outstanding_o !== 4'd1) begin
            errors++;
            $display("FAIL div_issue: outstanding=%0d, required 1", outstanding_o);
        end
        set_id(5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
        for (int k = 0; k < 3; k++) begin
            lo_done = (k == 2); lo_waddr = 5'd3;
            settle;
            checks++;
            if (stall_o !== 1'b1) begin
                errors++;
                $display("FAIL raw_stall_%0d: stall=%b, required 1", k, stall_o);
            end
            tick;
        end
        lo_done = 0;
        checks++;
        if (outstanding_o !== 4'd0) begin
            errors++;
            $display("FAIL div_done: outstanding=%0d, required 0", outstanding_o);
        end
        settle;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_release: stall=%b, required 0", stall_o);
        end
        tick;
        checks++;
        if (e_valid_o !== 1'b1 || e_rd_o !== 5'd4 || e_long_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_issue: valid=%b rd=%0d long=%b, required 1 4 0", e_valid_o, e_rd_o, e_long_o);
        end
        idle;
        tick;
    endtask

    task automatic test_max_out;
        drain;
        for (int k = 0; k < MAXO; k++) begin
            set_id(5'd0, 0, 5'd0, 0, 5'(8 + k), 1, 1);
            tick;
        end
        set_id(5'd0, 0, 5'd0, 0, 5'd12, 1, 1);
        lo_done = 1; lo_waddr = 5'd8;
        settle;
        checks++;
        if (stall_o !== 1'b1 || outstanding_o !== 4'd4) begin
            errors++;
            $display("FAIL max_out_stall: stall=%b out=%0d, required 1 4", stall_o, outstanding_o);
        end
        tick;
        checks++;
        if (outstanding_o !== 4'd3) begin
            errors++;
            $display("FAIL max_out_done: outstanding=%0d, required 3", outstanding_o);
        end
        lo_waddr = 5'd9;
        settle;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL issue_with_done_stall: stall=%b, required 0", stall_o);
        end
        tick;
        checks++;
        if (outstanding_o !== 4'd3) begin
            errors++;
            $display("FAIL issue_with_done_hold: outstanding=%0d, required 3", outstanding_o);
        end
        lo_done = 0;
        set_id(5'd0, 0, 5'd0, 0, 5'd13, 1, 1);
        tick;
        checks++;
        if (outstanding_o !== 4'd4) begin
            errors++;
            $display("FAIL refill: outstanding=%0d, required 4", outstanding_o);
        end
        idle;
    endtask

    task automatic test_backpressure;
        drain;
        set_id(5'd0, 0, 5'd0, 0, 5'd20, 1, 1);
        tick;
        set_id(5'd1, 1, 5'd2, 1, 5'd21, 1, 0);
        rf_rs1 = 32'h11110001; rf_rs2 = 32'h22220002;
        tick;
        e_ready = 0;
        set_id(5'd2, 1, 5'd1, 1, 5'd22, 1, 0);
        rf_rs1 = 32'h99; rf_rs2 = 32'h98;
        for (int k = 0; k < 3; k++) begin
            settle;
            checks++;
            if (stall_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall_%0d: stall=%b, required 1", k, stall_o);
            end
            tick;
            checks++;
            if (e_valid_o !== 1'b1 || e_rs1_o !== 32'h11110001 || e_rs2_o !== 32'h22220002 || e_rd_o !== 5'd21 || e_rd_wr_o !== 1'b1 || e_long_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b rs1=%h rs2=%h rd=%0d, required 1 11110001 22220002 21", k, e_valid_o, e_rs1_o, e_rs2_o, e_rd_o);
            end
        end
        flush = 1;
        tick;
        flush = 0;
        checks++;
        if (e_valid_o !== 1'b0 || outstanding_o !== 4'd1) begin
            errors++;
            $display("FAIL flush: valid=%b out=%0d, required 0 1", e_valid_o, outstanding_o);
        end
        e_ready = 1;
        set_id(5'd20, 1, 5'd0, 0, 5'd23, 1, 0);
        settle;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_pending: stall=%b, required 1", stall_o);
        end
        idle;
        tick;
    endtask

    task automatic test_zero;
        drain;
        set_id(5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
        tick;
        checks++;
        if (outstanding_o !== 4'd1) begin
            errors++;
            $display("FAIL rd0_long_count: outstanding=%0d, required 1", outstanding_o);
        end
        set_id(5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
        rf_rs1 = 32'h5555;
        fwd_wr = 3'b001; fwd_waddr = 15'd0; fwd_data = {64'd0, 32'hFFFFFFFF};
        settle;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rd0_no_pending: stall=%b, required 0", stall_o);
        end
        tick;
        checks++;
        if (e_valid_o !== 1'b1 || e_rs1_o !== 32'd0) begin
            errors++;
            $display("FAIL rs0_zero: valid=%b rs1=%h, required 1 00000000", e_valid_o, e_rs1_o);
        end
        idle;
    endtask

    task automatic test_random;
        drain;
        for (int n = 0; n < 400; n++) begin
            set_id(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3) == 0);
            id_valid = $urandom_range(0, 3) != 0;
            rf_rs1 = $urandom; rf_rs2 = $urandom;
            fwd_wr = 3'($urandom);
            for (int j = 0; j < 3; j++) begin
                fwd_waddr[j*5 +: 5] = 5'($urandom_range(0, 7));
                fwd_data[j*32 +: 32] = $urandom;
                fwd_ld[j] = $urandom_range(0, 3) == 0;
            end
            lo_done = $urandom_range(0, 2) == 0;
            lo_waddr = 5'($urandom_range(0, 7));
            e_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            settle;
            checks++;
            if (stall_o !== exp_stall) begin
                errors++;
                $display("FAIL rand_stall[%0d]: stall=%b, required %b", n, stall_o, exp_stall);
            end
            tick;
            checks++;
            if (e_valid_o !== ev || outstanding_o !== 4'(cnt)) begin
                errors++;
                $display("FAIL rand_state[%0d]: valid=%b out=%0d, required %b %0d", n, e_valid_o, outstanding_o, ev, cnt);
            end
            checks++;
            if (e_rs1_o !== ers1 || e_rs2_o !== ers2 || e_rd_o !== erd || e_rd_wr_o !== erdwr || e_long_o !== elong) begin
                errors++;
                $display("FAIL rand_ereg[%0d]: rs1=%h rs2=%h rd=%0d wr=%b long=%b, required %h %h %0d %b %b",
                         n, e_rs1_o, e_rs2_o, e_rd_o, e_rd_wr_o, e_long_o, ers1, ers2, erd, erdwr, elong);
            end
        end
        idle;
    endtask

    initial begin
        test_reset;
        test_forward;
        test_load_use;
        test_long_dep;
        test_max_out;
        test_backpressure;
        test_zero;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
